// File: rtl/nand4_event_monitor.sv
// Synchronises both NAND outputs, counts their falling edges per channel and
// publishes the per-window counts through a valid/ready report port.
module nand4_event_monitor #(
    parameter int CNT_W      = 8,
    parameter int WIN_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             p1y,
    input  logic             p2y,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_c1,
    output logic [CNT_W-1:0] rpt_c2,
    output logic             rpt_overrun
);
    localparam int               WIN_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [1:0]       s1_q, s2_q, s3_q;   // bit 0 = channel 1, bit 1 = channel 2
    logic [1:0]       evt;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CNT_W-1:0] sum1, sum2;
    logic [WIN_W-1:0] win_q, win_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] rpt_c1_q, rpt_c1_d, rpt_c2_q, rpt_c2_d;
    logic             win_end, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
        return (e && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    // Sync flops reset to the NAND idle level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
            s3_q <= 2'b11;
        end else begin
            s1_q <= {p2y, p1y};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign evt     = s3_q & ~s2_q;
    assign sum1    = sat_inc(cnt1_q, evt[0]);
    assign sum2    = sat_inc(cnt2_q, evt[1]);
    assign win_end = (state_q == RUN) && en && (win_q == WIN_LAST);
    assign accept  = rpt_valid_q && rpt_ready;

    always_comb begin
        state_d     = state_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        win_d       = win_q;
        rpt_valid_d = rpt_valid_q;
        rpt_c1_d    = rpt_c1_q;
        rpt_c2_d    = rpt_c2_q;
        ovr_d       = ovr_q;

        case (state_q)
            IDLE: begin
                cnt1_d = '0;
                cnt2_d = '0;
                win_d  = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en || win_end) begin
                    // Dropping en discards the partial window; a window end restarts it.
                    cnt1_d = '0;
                    cnt2_d = '0;
                    win_d  = '0;
                    if (!en) state_d = IDLE;
                end else begin
                    cnt1_d = sum1;
                    cnt2_d = sum2;
                    win_d  = win_q + WIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (win_end) begin
            if (!rpt_valid_q || accept) begin
                rpt_c1_d    = sum1;
                rpt_c2_d    = sum2;
                rpt_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            rpt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            win_q       <= '0;
            rpt_valid_q <= 1'b0;
            rpt_c1_q    <= '0;
            rpt_c2_q    <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            win_q       <= win_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_c1_q    <= rpt_c1_d;
            rpt_c2_q    <= rpt_c2_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rpt_valid   = rpt_valid_q;
    assign rpt_c1      = rpt_c1_q;
    assign rpt_c2      = rpt_c2_q;
    assign rpt_overrun = ovr_q;

endmodule
